// File: rtl/bcd_serial_sub.sv
// Digit-serial packed-BCD subtractor: returns |a - b| as BCD plus a sign flag.
// One digit per clock, LSD first; a final borrow triggers a serial ten's complement.
module bcd_serial_sub #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  neg,
    output logic                  err,
    output logic                  busy,
    output logic                  done
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SUB  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  r_q, r_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          borrow_q, borrow_d;
    logic [W-1:0]  diff_q, diff_d;
    logic          neg_q, neg_d;
    logic          err_q, err_d;

    logic [3:0]        dig_x, dig_y, r_dig;
    logic signed [4:0] t;
    logic [4:0]        t_adj;
    logic              last_dig;
    logic              in_bad;

    // Operand digit selection: SUB works on a_i - b_i, FIX on 0 - r_i.
    always_comb begin
        dig_x = '0;
        dig_y = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                dig_x = (state_q == S_SUB) ? a_q[4*i +: 4] : 4'd0;
                dig_y = (state_q == S_SUB) ? b_q[4*i +: 4] : r_q[4*i +: 4];
            end
        end
    end

    assign t        = $signed({1'b0, dig_x}) - $signed({1'b0, dig_y}) - $signed({4'b0000, borrow_q});
    assign t_adj    = t + 5'sd10;
    assign r_dig    = t[4] ? t_adj[3:0] : t[3:0];
    assign last_dig = (idx_q == IW'(DIGITS - 1));

    always_comb begin
        in_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
                in_bad = 1'b1;
            end
        end
    end

    // Result registers are loaded on the edge entering FIN so they are valid alongside done.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        neg_d    = neg_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                if (start) begin
                    a_d = a;
                    b_d = b;
                    if (in_bad) begin
                        state_d = S_FIN;
                        err_d   = 1'b1;
                        diff_d  = '0;
                        neg_d   = 1'b0;
                    end else begin
                        state_d  = S_SUB;
                        idx_d    = '0;
                        borrow_d = 1'b0;
                        r_d      = '0;
                    end
                end
            end
            S_SUB, S_FIX: begin
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (idx_q == IW'(i)) begin
                        r_d[4*i +: 4] = r_dig;
                    end
                end
                borrow_d = t[4];
                idx_d    = IW'(idx_q + 1'b1);
                if (last_dig) begin
                    idx_d = '0;
                    if (state_q == S_SUB && t[4]) begin
                        state_d  = S_FIX;
                        borrow_d = 1'b0;
                    end else begin
                        state_d = S_FIN;
                        diff_d  = r_d;
                        neg_d   = (state_q == S_FIX);
                        err_d   = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
        end
    end

    assign diff = diff_q;
    assign neg  = neg_q;
    assign err  = err_q;
    assign busy = (state_q == S_SUB) || (state_q == S_FIX);
    assign done = (state_q == S_FIN);

endmodule

// File: tb/tb_bcd_serial_sub.sv
// Randomised and directed bench for bcd_serial_sub (DIGITS=4) against an integer-arithmetic model.
module tb_bcd_serial_sub;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [15:0] diff;
    logic        neg, err, busy, done;

    int total = 0;
    int bad   = 0;

    bcd_serial_sub #(.DIGITS(D)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .diff(diff), .neg(neg), .err(err), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int bcd_val(input logic [15:0] v);
        int s = 0;
        int p = 1;
        for (int i = 0; i < D; i++) begin
            s += int'(v[4*i +: 4]) * p;
            p *= 10;
        end
        return s;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        int x = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x /= 10;
        end
        return r;
    endfunction

    function automatic bit has_bad(input logic [15:0] x, input logic [15:0] y);
        for (int i = 0; i < D; i++)
            if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    // Expected result from plain integer arithmetic.
    task automatic model(input logic [15:0] x, input logic [15:0] y, output logic [15:0] ed,
                         output logic en, output logic ee, output int elat);
        int va, vb;
        if (has_bad(x, y)) begin
            ed = '0; en = 1'b0; ee = 1'b1; elat = 1;
        end else begin
            va = bcd_val(x);
            vb = bcd_val(y);
            ee = 1'b0;
            en = (va < vb);
            ed = to_bcd(en ? vb - va : va - vb);
            elat = en ? 2 * D + 1 : D + 1;
        end
    endtask

    // Drives one request and observes until done; lat=-1 on timeout.
    task automatic do_op(input logic [15:0] x, input logic [15:0] y, output int lat, output int busyc,
                         output int chg, output logic [15:0] od, output logic on, output logic oe);
        logic [15:0] prev;
        @(posedge clk); #1;
        a = x; b = y; start = 1'b1;
        prev = diff;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; busyc = 0; chg = 0;
        while (!done && lat < 100) begin
            if (busy) busyc++;
            if (diff !== prev) chg++;
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
        od = diff; on = neg; oe = err;
    endtask

    task automatic check_op(input string nm, input logic [15:0] x, input logic [15:0] y);
        int lat, busyc, chg, elat;
        logic [15:0] od, ed;
        logic on, oe, en, ee;
        model(x, y, ed, en, ee, elat);
        do_op(x, y, lat, busyc, chg, od, on, oe);
        total++; if (od !== ed) begin bad++; $display("FAIL %s diff a=%h b=%h got=%h exp=%h", nm, x, y, od, ed); end
        total++; if (on !== en) begin bad++; $display("FAIL %s neg a=%h b=%h got=%b exp=%b", nm, x, y, on, en); end
        total++; if (oe !== ee) begin bad++; $display("FAIL %s err a=%h b=%h got=%b exp=%b", nm, x, y, oe, ee); end
        total++; if (lat !== elat) begin bad++; $display("FAIL %s latency a=%h b=%h got=%0d exp=%0d", nm, x, y, lat, elat); end
        total++; if (busyc !== elat - 1) begin bad++; $display("FAIL %s busy_cycles a=%h b=%h got=%0d exp=%0d", nm, x, y, busyc, elat - 1); end
        total++; if (chg !== 0) begin bad++; $display("FAIL %s output_hold a=%h b=%h got=%0d exp=0", nm, x, y, chg); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({diff, neg, err, busy, done} !== 20'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", {diff, neg, err, busy, done}); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset_idle got=%b exp=00", {busy, done}); end
    endtask

    task automatic test_directed();
        check_op("plan_pos",   16'h5321, 16'h1234);
        check_op("plan_neg",   16'h1234, 16'h5321);
        check_op("ripple",     16'h1000, 16'h0001);
        check_op("zero_neg",   16'h0000, 16'h0001);
        check_op("equal",      16'h9999, 16'h9999);
        check_op("bad_nibble", 16'h12A4, 16'h0000);
        check_op("bad_b",      16'h0000, 16'h000F);
        check_op("max_neg",    16'h0000, 16'h9999);
    endtask

    task automatic test_random();
        logic [15:0] x, y;
        for (int n = 0; n < 40; n++) begin
            x = to_bcd(int'($urandom_range(0, 9999)));
            y = to_bcd(int'($urandom_range(0, 9999)));
            if ($urandom_range(0, 7) == 0) x[4*$urandom_range(0, 3) +: 4] = 4'(10 + $urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0) y = x;
            check_op("random", x, y);
        end
    endtask

    task automatic test_busy_ignore();
        int cyc, pulses, first;
        logic [15:0] d5;
        logic n5;
        @(posedge clk); #1;
        a = 16'h5321; b = 16'h1234; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1; pulses = 0; first = -1; d5 = '0; n5 = 1'b0;
        while (cyc < 14) begin
            if (cyc == 2) begin a = 16'h0000; b = 16'h0001; start = 1'b1; end
            if (cyc == 3) start = 1'b0;
            if (done) begin
                pulses++;
                if (first < 0) begin first = cyc; d5 = diff; n5 = neg; end
            end
            @(posedge clk); #1;
            cyc++;
        end
        total++; if (first !== 5) begin bad++; $display("FAIL ignore_latency got=%0d exp=5", first); end
        total++; if (pulses !== 1) begin bad++; $display("FAIL ignore_pulses got=%0d exp=1", pulses); end
        total++; if (d5 !== 16'h4087) begin bad++; $display("FAIL ignore_diff got=%h exp=4087", d5); end
        total++; if (n5 !== 1'b0) begin bad++; $display("FAIL ignore_neg got=%b exp=0", n5); end
    endtask

    task automatic test_midreset();
        int pulses;
        @(posedge clk); #1;
        a = 16'h5321; b = 16'h1234; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; pulses = 0;
        for (int c = 1; c < 3; c++) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if ({diff, neg, err, busy, done} !== 20'd0) begin bad++; $display("FAIL midreset_outputs got=%h exp=0", {diff, neg, err, busy, done}); end
        for (int c = 0; c < 8; c++) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL midreset_done got=%0d exp=0", pulses); end
        check_op("after_reset", 16'h0050, 16'h0049);
    endtask

    task automatic test_back_to_back();
        int lat, wait_c;
        logic [15:0] ed;
        logic en, ee;
        int elat;
        @(posedge clk); #1;
        a = 16'h0100; b = 16'h0200; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; wait_c = 0;
        while (!done && wait_c < 100) begin @(posedge clk); #1; wait_c++; end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_first_done got=%b exp=1", done); end
        total++; if (diff !== 16'h0100 || neg !== 1'b1) begin bad++; $display("FAIL b2b_first got=%h/%b exp=0100/1", diff, neg); end
        a = 16'h7777; b = 16'h0778; start = 1'b1;
        model(16'h7777, 16'h0778, ed, en, ee, elat);
        @(posedge clk); #1;
        start = 1'b0; lat = 1;
        while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
        total++; if (lat !== elat) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, elat); end
        total++; if (diff !== ed || neg !== en || err !== ee) begin bad++; $display("FAIL b2b_second got=%h/%b/%b exp=%h/%b/%b", diff, neg, err, ed, en, ee); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_midreset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
